// File: rtl/sprite_row_fetch.sv
// Sprite row fetcher: latches one sprite record per request and walks its pixel row.
// Latency: first address valid 1 clk after sprite_on is sampled; one address step per pixel_tick.
// Backpressure: 4-phase level handshake; count_finished is held until sprite_on falls, then no re-trigger until it rises again.
module sprite_row_fetch #(
    parameter int ADDR_W   = 14,
    parameter int LEN_W    = 5,
    parameter int BASE_LSB = 0,
    parameter int LEN_LSB  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick,
    input  logic              sprite_on,
    input  logic [31:0]       sprite_datas,
    output logic [ADDR_W-1:0] memory_address,
    output logic              addr_valid,
    output logic              count_finished,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [LEN_W-1:0]   counter;
    logic [LEN_W-1:0]   counter_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic               valid_nxt;
    logic               fin_nxt;
    logic               busy_nxt;

    logic [ADDR_W-1:0]  base_field;
    logic [LEN_W-1:0]   len_field;

    // Record fields; every other bit of sprite_datas is don't-care.
    assign base_field = sprite_datas[BASE_LSB +: ADDR_W];
    assign len_field  = sprite_datas[LEN_LSB +: LEN_W];

    logic unused_datas;
    assign unused_datas = &{1'b0, sprite_datas};

    // State register; reset drops any pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort (sprite_on low) wins over a pixel tick.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                state_nxt = sprite_on ? FETCH : IDLE;
            end
            FETCH: begin
                if (!sprite_on) begin
                    state_nxt = IDLE;
                end else if (pixel_tick && (counter == len_q)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                state_nxt = sprite_on ? DONE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and row bookkeeping.
    always_comb begin
        addr_nxt    = memory_address;
        counter_nxt = counter;
        len_nxt     = len_q;
        valid_nxt   = addr_valid;
        fin_nxt     = count_finished;
        busy_nxt    = busy;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                fin_nxt   = 1'b0;
                busy_nxt  = 1'b0;
                if (sprite_on) begin
                    // The record is captured only here; later changes are ignored.
                    addr_nxt    = base_field;
                    len_nxt     = len_field;
                    counter_nxt = '0;
                    valid_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            FETCH: begin
                if (!sprite_on) begin
                    valid_nxt = 1'b0;
                    fin_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (pixel_tick) begin
                    if (counter < len_q) begin
                        // Address wraps naturally at 2^ADDR_W.
                        addr_nxt    = memory_address + ADDR_W'(1);
                        counter_nxt = counter + LEN_W'(1);
                    end else begin
                        // Final pixel consumed: keep the last address, report completion.
                        valid_nxt = 1'b0;
                        fin_nxt   = 1'b1;
                    end
                end
            end
            DONE: begin
                valid_nxt = 1'b0;
                fin_nxt   = 1'b1;
                busy_nxt  = 1'b1;
                if (!sprite_on) begin
                    fin_nxt  = 1'b0;
                    busy_nxt = 1'b0;
                end
            end
            default: begin
                addr_nxt    = '0;
                counter_nxt = '0;
                len_nxt     = '0;
                valid_nxt   = 1'b0;
                fin_nxt     = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    // Registered outputs and row bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memory_address <= '0;
            counter        <= '0;
            len_q          <= '0;
            addr_valid     <= 1'b0;
            count_finished <= 1'b0;
            busy           <= 1'b0;
        end else begin
            memory_address <= addr_nxt;
            counter        <= counter_nxt;
            len_q          <= len_nxt;
            addr_valid     <= valid_nxt;
            count_finished <= fin_nxt;
            busy           <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_sprite_row_fetch.sv
// Bench for sprite_row_fetch: directed rows, scoreboard of expected addresses and completions.
// Stimulus drives on posedge+1, monitor samples on negedge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_sprite_row_fetch;

    logic        clk;
    logic        reset;
    logic        pixel_tick;
    logic        sprite_on;
    logic [31:0] sprite_datas;
    logic [13:0] memory_address;
    logic        addr_valid;
    logic        count_finished;
    logic        busy;

    sprite_row_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .pixel_tick     (pixel_tick),
        .sprite_on      (sprite_on),
        .sprite_datas   (sprite_datas),
        .memory_address (memory_address),
        .addr_valid     (addr_valid),
        .count_finished (count_finished),
        .busy           (busy)
    );

    typedef struct {
        bit          fin;
        logic [13:0] addr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   tick_mode = 0;
    int   tcnt = 0;
    logic prev_cf = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [13:0] base, input logic [4:0] len);
        // Upper bits carry junk that the DUT must ignore.
        return 32'hA5A0_0000 | 32'(base) | (32'(len) << 14);
    endfunction

    // Pixel tick generator: 0 = never, 1 = every clk, 2 = every other clk.
    initial begin
        pixel_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            case (tick_mode)
                1:       pixel_tick = 1'b1;
                2:       pixel_tick = tcnt[0];
                default: pixel_tick = 1'b0;
            endcase
        end
    end

    // Monitor: consumed pixels and completion rises are popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (addr_valid && pixel_tick && sprite_on) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_addr: got %0h expected nothing", memory_address);
                end else begin
                    e = sb.pop_front();
                    chk("pixel_kind_is_addr", 32'(e.fin), 32'(0));
                    chk("pixel_addr", 32'(memory_address), 32'(e.addr));
                end
            end
            if (count_finished && !prev_cf) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_finish: got 1 expected no finish");
                end else begin
                    e = sb.pop_front();
                    chk("finish_kind", 32'(e.fin), 32'(1));
                end
            end
        end
        prev_cf = count_finished;
    end

    task automatic push_row(input logic [13:0] base, input int npix, input bit fin);
        exp_t e;
        logic [13:0] a;
        a = base;
        for (int i = 0; i < npix; i++) begin
            e.fin  = 1'b0;
            e.addr = a;
            sb.push_back(e);
            a = a + 14'd1;
        end
        if (fin) begin
            e.fin  = 1'b1;
            e.addr = '0;
            sb.push_back(e);
        end
    endtask

    // Raise a request and check the first address one clk after it is sampled.
    task automatic req(input logic [13:0] base, input logic [4:0] len);
        sprite_datas = mk(base, len);
        sprite_on    = 1'b1;
        @(posedge clk);
        #1;
        chk("req_addr_valid", 32'(addr_valid), 32'(1));
        chk("req_busy", 32'(busy), 32'(1));
        chk("req_first_addr", 32'(memory_address), 32'(base));
    endtask

    task automatic wait_finish(input string name);
        int n;
        n = 0;
        while (!count_finished && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!count_finished) begin
            errors++;
            $display("FAIL %s: count_finished got 0 expected 1 within 300 clks", name);
        end
    endtask

    task automatic release_req();
        sprite_on = 1'b0;
        @(posedge clk);
        #1;
        chk("release_cf", 32'(count_finished), 32'(0));
        chk("release_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int ticks;
        reset        = 1'b0;
        sprite_on    = 1'b0;
        sprite_datas = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 32'(memory_address), 32'(0));
        chk("rst_valid", 32'(addr_valid), 32'(0));
        chk("rst_cf", 32'(count_finished), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic 20-pixel row, tick every other clk, hold then release.
        tick_mode = 2;
        push_row(14'h0100, 20, 1'b1);
        req(14'h0100, 5'd19);
        wait_finish("basic_finish");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("basic_cf_hold", 32'(count_finished), 32'(1));
            chk("basic_valid_low", 32'(addr_valid), 32'(0));
        end
        chk("basic_last_addr", 32'(memory_address), 32'h0113);
        release_req();

        // Single pixel row, tick every clk.
        tick_mode = 1;
        push_row(14'h2000, 1, 1'b1);
        req(14'h2000, 5'd0);
        @(posedge clk);
        #1;
        chk("single_cf", 32'(count_finished), 32'(1));
        chk("single_valid", 32'(addr_valid), 32'(0));
        chk("single_addr", 32'(memory_address), 32'h2000);
        release_req();

        // Address wrap at the top of sprite memory.
        push_row(14'h3FFE, 4, 1'b1);
        req(14'h3FFE, 5'd3);
        wait_finish("wrap_finish");

        // Handshake hold: new record while done must not restart the fetch.
        sprite_datas = mk(14'h0777, 5'd2);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold_cf", 32'(count_finished), 32'(1));
            chk("hold_valid", 32'(addr_valid), 32'(0));
            chk("hold_busy", 32'(busy), 32'(1));
        end
        release_req();
        push_row(14'h0777, 3, 1'b1);
        req(14'h0777, 5'd2);
        wait_finish("rehs_finish");
        release_req();

        // Abort after 5 ticks of a 20-pixel row.
        tick_mode = 2;
        push_row(14'h0200, 5, 1'b0);
        req(14'h0200, 5'd19);
        ticks = 0;
        n = 0;
        while (ticks < 5 && n < 100) begin
            @(negedge clk);
            if (addr_valid && pixel_tick) ticks++;
            n++;
        end
        chk("abort_ticks_seen", 32'(ticks), 32'(5));
        @(posedge clk);
        #1;
        sprite_on = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_valid", 32'(addr_valid), 32'(0));
        chk("abort_cf", 32'(count_finished), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        repeat (4) @(posedge clk);
        #1;
        push_row(14'h0040, 3, 1'b1);
        req(14'h0040, 5'd2);
        wait_finish("after_abort_finish");
        release_req();

        // Asynchronous reset in the middle of a row at 0x0105.
        push_row(14'h0100, 5, 1'b0);
        req(14'h0100, 5'd19);
        n = 0;
        while (memory_address != 14'h0105 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reset_reached_0105", 32'(memory_address), 32'h0105);
        reset = 1'b0;
        #1;
        chk("midrst_addr", 32'(memory_address), 32'(0));
        chk("midrst_valid", 32'(addr_valid), 32'(0));
        chk("midrst_cf", 32'(count_finished), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        sprite_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("postrst_valid", 32'(addr_valid), 32'(0));
        chk("postrst_busy", 32'(busy), 32'(0));

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
